sumador_multiciclo: RTL

Parametrised multicycle adder/subtractor for the ALU datapath. It is the next generation of the fixed 4-bit ripple adder built from 2-bit slices.
- Operands are latched on a start request.
- Each clock adds one CHUNK-bit slice, rippling the carry through a register.
- A one-cycle done pulse signals the result.
- This trades latency for area, which suits tile-limited silicon.

---
 rtl/sumador_pkg.sv | 24 ++
 rtl/sumador_slice.sv | 17 +
 rtl/sumador_multiciclo.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sumador_pkg.sv
// Shared types and helpers for the multicycle adder/subtractor.
// Optional feature macro used by the top: SUMADOR_OVERFLOW_EN.
package sumador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2, evaluated at elaboration to size the slice counter.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sumador_slice.sv
// Combinational CHUNK-bit adder slice; the top reuses one instance every cycle.
module sumador_slice #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] A,
  input  logic [CHUNK-1:0] B,
  input  logic             C_in,
  output logic [CHUNK-1:0] S,
  output logic             C_out
);

  logic [CHUNK:0] total;

  assign total      = {1'b0, A} + {1'b0, B} + {{CHUNK{1'b0}}, C_in};
  assign {C_out, S} = total;

endmodule

// File: rtl/sumador_multiciclo.sv
// Multicycle adder/subtractor: one CHUNK-bit slice per clock, carry rippled through a register.
// Define SUMADOR_OVERFLOW_EN to add the signed-overflow output V.
module sumador_multiciclo
  import sumador_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             busy,
`ifdef SUMADOR_OVERFLOW_EN
  output logic             V,
`endif
  output logic             done
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NCHUNK - 1);

  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("sumador_multiciclo: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
    end
  endgenerate

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] s_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             c_out_q;
  logic             busy_q;
  logic             done_q;

  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK-1:0] sum_slice;
  logic             carry_d;

  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_slice = a_q[i*CHUNK +: CHUNK];
        b_slice = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  sumador_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .A    (a_slice),
    .B    (b_slice),
    .C_in (carry_q),
    .S    (sum_slice),
    .C_out(carry_d)
  );

  // Only the slice selected by the counter is overwritten; the rest hold.
  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_s_write
      assign s_d[gi*CHUNK +: CHUNK] = (cnt_q == CNT_W'(gi)) ? sum_slice : s_q[gi*CHUNK +: CHUNK];
    end
  endgenerate

`ifdef SUMADOR_OVERFLOW_EN
  logic v_q;
  logic v_d;
  // On the last slice sum_slice holds the result MSB.
  assign v_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_slice[CHUNK-1] != a_q[WIDTH-1]);
  assign V   = v_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUMADOR_OVERFLOW_EN
      v_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= sub ? ~B : B;
            carry_q <= sub ? 1'b1 : C_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          s_q     <= s_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_SLICE) begin
            c_out_q <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
`ifdef SUMADOR_OVERFLOW_EN
            v_q     <= v_d;
`endif
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign S     = s_q;
  assign C_out = c_out_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
